y86_dmem_responder: RTL

- Data-memory responder serving load/store requests issued by the pipeline memory stage (rmmovq, pushq and call stores; mrmovq, popq and ret loads).
- Replaces the zero-latency array with a handshaked, fixed-latency, single-outstanding memory.
- Flags bad addresses so the memory stage can raise ADR status.
- Sits between the memory stage and the backing storage; req_ready low is the memory-stage stall source.

---
 rtl/y86_dmem_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/y86_dmem_responder.sv
// Single-outstanding Y86 data-memory responder with fixed request-to-response latency.
// Response appears LATENCY cycles after acceptance; req_ready is low from acceptance through the handshake edge.
module y86_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [63:0] LIMIT    = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic               wr_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx_q;
    logic [63:0]        wdata_q;
    logic [63:0]        mem [DEPTH_WORDS];

    logic               req_err;
    logic [IDX_W-1:0]   req_idx;
    logic               accept;
    logic               access;
    logic               commit;

    // Full 64-bit range compare so high address bits never alias into the array.
    assign req_idx = req_addr[IDX_W+2:3];
    assign req_err = (req_addr[2:0] != 3'd0) || (req_addr >= LIMIT);
    assign accept  = (state == IDLE) && req_valid;
    assign access  = (state == BUSY) && (cnt == 4'd0);
    assign commit  = access && wr_q && !err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (cnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 64'd0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                err_q   <= req_err;
                idx_q   <= req_idx;
                wdata_q <= req_wdata;
                cnt     <= CNT_INIT;
            end else if ((state == BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            if (access) begin
                resp_err   <= err_q;
                resp_rdata <= (!wr_q && !err_q) ? mem[idx_q] : 64'd0;
            end else if ((state == RESP) && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= 64'd0;
            end
        end
    end

    // Storage is not reset; a reset before the access edge forces state to IDLE, so no commit.
    always_ff @(posedge clk) begin
        if (commit) mem[idx_q] <= wdata_q;
    end

endmodule
